cpu_eu: RTL and testbench

Execution unit of the 301 16-bit RISC processor, sitting directly downstream of the control unit sequencer. It holds the program counter, instruction register, an 8 x 16 register file and the ALU. It executes the per-cycle control word the sequencer drives, and returns IR and the N/Z/C ALU flags to it. It also drives the address and write-data buses of the unified instruction/data memory.

---
 rtl/cpu_eu.sv | 136 +++++++++++++
 tb/tb_cpu_eu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_eu.sv
// Execution unit of the 301 RISC: PC, IR, 8x16 register file and ALU,
// driven cycle by cycle by the sequencer's control word.
module cpu_eu #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  W_Adr,
    input  logic [2:0]  R_Adr,
    input  logic [2:0]  S_Adr,
    input  logic        adr_sel,
    input  logic        s_sel,
    input  logic        pc_ld,
    input  logic        pc_inc,
    input  logic        pc_sel,
    input  logic        ir_ld,
    input  logic        rw_en,
    input  logic [3:0]  alu_op,
    input  logic [15:0] D_in,
    output logic [15:0] Address,
    output logic [15:0] D_out,
    output logic [15:0] IR,
    output logic        N,
    output logic        Z,
    output logic        C
);

    typedef enum logic [3:0] {
        ALU_PASS = 4'b0000,
        ALU_ADD  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_INC  = 4'b0011,
        ALU_DEC  = 4'b0100,
        ALU_SHL  = 4'b0101,
        ALU_SHR  = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_XOR  = 4'b1001,
        ALU_NOT  = 4'b1010
    } alu_op_e;

    logic [15:0] rf [8];
    logic [15:0] pc;
    logic [15:0] r_data;
    logic [15:0] s_data;
    logic [15:0] b_opnd;
    logic [15:0] y;
    logic        carry;
    logic [16:0] wide;
    logic [15:0] br_off;
    logic [15:0] pc_next;
    alu_op_e     op;

    // Register reads are unbypassed: a same-cycle write is seen next cycle.
    assign r_data  = rf[R_Adr];
    assign s_data  = rf[S_Adr];
    assign b_opnd  = s_sel ? D_in : s_data;
    assign op      = alu_op_e'(alu_op);

    assign Address = adr_sel ? r_data : pc;
    assign D_out   = s_data;
    assign N       = y[15];
    assign Z       = (y == '0);
    assign C       = carry;

    always_comb begin
        y     = '0;
        carry = 1'b0;
        wide  = '0;
        case (op)
            ALU_PASS: y = b_opnd;
            ALU_ADD: begin
                wide  = {1'b0, r_data} + {1'b0, b_opnd};
                y     = wide[15:0];
                carry = wide[16];
            end
            // Bit 16 of the widened difference is the unsigned borrow.
            ALU_SUB: begin
                wide  = {1'b0, r_data} - {1'b0, b_opnd};
                y     = wide[15:0];
                carry = wide[16];
            end
            ALU_INC: begin
                y     = b_opnd + 16'd1;
                carry = &b_opnd;
            end
            ALU_DEC: begin
                y     = b_opnd - 16'd1;
                carry = ~|b_opnd;
            end
            ALU_SHL: begin
                y     = {b_opnd[14:0], 1'b0};
                carry = b_opnd[15];
            end
            ALU_SHR: begin
                y     = {1'b0, b_opnd[15:1]};
                carry = b_opnd[0];
            end
            ALU_AND: y = r_data & b_opnd;
            ALU_OR:  y = r_data | b_opnd;
            ALU_XOR: y = r_data ^ b_opnd;
            ALU_NOT: y = ~b_opnd;
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

    // Relative branches use the IR held before the edge, even when ir_ld is set.
    assign br_off = {{8{IR[7]}}, IR[7:0]};

    always_comb begin
        pc_next = pc;
        if (pc_ld)
            pc_next = pc_sel ? r_data : (pc + br_off);
        else if (pc_inc)
            pc_next = pc + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
            IR <= '0;
            for (int unsigned i = 0; i < 8; i++)
                rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (ir_ld)
                IR <= D_in;
            if (rw_en)
                rf[W_Adr] <= y;
        end
    end

endmodule

// File: tb/tb_cpu_eu.sv
// Self-checking bench for cpu_eu: directed scenarios plus random control
// words checked against an arithmetic reference model of PC, IR and RF.
module tb_cpu_eu;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
    logic [3:0]  alu_op;
    logic [15:0] D_in, Address, D_out, IR;
    logic        N, Z, C;

    logic [15:0] mem [256];
    logic [15:0] m_rf [8];
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    int checks = 0;
    int errors = 0;

    cpu_eu #(.PC_RESET(16'h0000)) dut (
        .clk(clk), .reset(reset), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_sel(pc_sel), .ir_ld(ir_ld), .rw_en(rw_en), .alu_op(alu_op),
        .D_in(D_in), .Address(Address), .D_out(D_out), .IR(IR),
        .N(N), .Z(Z), .C(C)
    );

    always #5 clk = ~clk;

    assign D_in = mem[Address[7:0]];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_alu(input logic [3:0] op, input logic [15:0] r,
                                            input logic [15:0] b);
        int unsigned ri, bi, yv;
        bit c;
        ri = r;
        bi = b;
        c  = 1'b0;
        case (op)
            4'd0: yv = bi;
            4'd1: begin yv = ri + bi; c = (yv > 65535); end
            4'd2: begin yv = ri - bi; c = (ri < bi); end
            4'd3: begin yv = bi + 1;  c = (bi == 65535); end
            4'd4: begin yv = bi - 1;  c = (bi == 0); end
            4'd5: begin yv = bi * 2;  c = (bi >= 32768); end
            4'd6: begin yv = bi / 2;  c = (bi % 2 == 1); end
            4'd7: yv = ri & bi;
            4'd8: yv = ri | bi;
            4'd9: yv = ri ^ bi;
            4'd10: yv = ~bi;
            default: yv = 0;
        endcase
        return {c, 16'(yv)};
    endfunction

    task automatic idle();
        reset = 0; W_Adr = 0; R_Adr = 0; S_Adr = 0; adr_sel = 0; s_sel = 0;
        pc_ld = 0; pc_inc = 0; pc_sel = 0; ir_ld = 0; rw_en = 0; alu_op = 0;
    endtask

    // One clock with the currently driven control word; called just after a negedge.
    task automatic tick();
        logic [15:0] r, s, addr, din, b, y;
        logic [16:0] res;
        int off;
        r    = m_rf[R_Adr];
        s    = m_rf[S_Adr];
        addr = adr_sel ? r : m_pc;
        din  = mem[addr[7:0]];
        b    = s_sel ? din : s;
        res  = ref_alu(alu_op, r, b);
        y    = res[15:0];
        #1;
        check("address", Address, addr);
        check("d_out", D_out, s);
        check("flag_n", {15'b0, N}, {15'b0, (y >= 16'h8000)});
        check("flag_z", {15'b0, Z}, {15'b0, (y == 16'h0000)});
        check("flag_c", {15'b0, C}, {15'b0, res[16]});
        @(posedge clk);
        if (reset) begin
            m_pc = 16'h0000;
            m_ir = 16'h0000;
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        end else begin
            off = int'(m_ir[7:0]);
            if (off >= 128) off = off - 256;
            if (rw_en) m_rf[W_Adr] = y;
            if (pc_ld) m_pc = pc_sel ? r : 16'(int'(m_pc) + off);
            else if (pc_inc) m_pc = 16'(int'(m_pc) + 1);
            if (ir_ld) m_ir = din;
        end
        @(negedge clk);
        check("ir", IR, m_ir);
    endtask

    task automatic peek_pc(input string tag, input logic [15:0] exp);
        logic save;
        save = adr_sel;
        adr_sel = 0;
        #1;
        check(tag, Address, exp);
        adr_sel = save;
    endtask

    task automatic set_reg(input logic [2:0] w, input logic [15:0] val);
        idle();
        mem[m_pc[7:0]] = val;
        s_sel = 1; rw_en = 1; W_Adr = w;
        tick();
        idle();
    endtask

    task automatic flags(input string tag, input logic [3:0] op, input logic [2:0] ra,
                         input logic [2:0] sa, input logic [2:0] nzc);
        idle();
        alu_op = op; R_Adr = ra; S_Adr = sa;
        #1;
        check(tag, {13'b0, N, Z, C}, {13'b0, nzc});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_pc = 16'h0000;
        m_ir = 16'h0000;
        mem[0] = 16'hF440;
        mem[1] = 16'h1234;
        mem[8'h40] = 16'h1111;
        mem[8'h80] = 16'h00FC;
        mem[8'h81] = 16'h0005;
        mem[8'h82] = 16'h0033;
        idle();
        @(negedge clk);

        // Reset with junk controls; model starts in reset state.
        reset = 1; W_Adr = 3'($urandom); R_Adr = 3'($urandom); S_Adr = 3'($urandom);
        adr_sel = 1; s_sel = 1; pc_ld = 1; pc_inc = 1; pc_sel = 1; ir_ld = 1; rw_en = 1;
        alu_op = 4'($urandom);
        @(posedge clk);
        @(negedge clk);
        idle();
        check("rst_ir", IR, 16'h0000);
        peek_pc("rst_pc", 16'h0000);
        check("rst_z", {15'b0, Z}, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            adr_sel = 1; R_Adr = 3'(i);
            #1;
            check("rst_rf", Address, 16'h0000);
        end
        idle();

        // FETCH then LDI
        ir_ld = 1; pc_inc = 1;
        tick();
        check("fetch_ir", IR, 16'hF440);
        peek_pc("fetch_pc", 16'h0001);
        idle();
        s_sel = 1; rw_en = 1; pc_inc = 1; W_Adr = 1;
        tick();
        idle();
        peek_pc("ldi_pc", 16'h0002);
        adr_sel = 1; R_Adr = 1;
        #1;
        check("ldi_rf1", Address, 16'h1234);

        // ALU flags {N,Z,C}
        set_reg(1, 16'hFFFF);
        set_reg(2, 16'h0001);
        flags("add_flags", 4'b0001, 1, 2, 3'b011);
        flags("sub_flags", 4'b0010, 2, 1, 3'b001);
        flags("shl_flags", 4'b0101, 0, 1, 3'b101);
        flags("dec_flags", 4'b0100, 0, 0, 3'b101);
        idle();
        alu_op = 4'b0010; R_Adr = 2; S_Adr = 1; rw_en = 1; W_Adr = 6;
        tick();
        idle();
        adr_sel = 1; R_Adr = 6;
        #1;
        check("sub_result", Address, 16'h0002);

        // Relative branches
        set_reg(6, 16'h0080);
        set_reg(7, 16'h0010);
        idle(); adr_sel = 1; R_Adr = 6; ir_ld = 1; tick();
        idle(); pc_ld = 1; pc_sel = 1; R_Adr = 7; tick();
        peek_pc("jmp_10", 16'h0010);
        idle(); pc_ld = 1; tick();
        peek_pc("br_back", 16'h000C);
        set_reg(6, 16'h0081);
        idle(); adr_sel = 1; R_Adr = 6; ir_ld = 1; tick();
        idle(); pc_ld = 1; pc_sel = 1; R_Adr = 7; tick();
        // Load wins over inc; the branch uses the pre-edge IR despite ir_ld.
        set_reg(6, 16'h0082);
        idle(); pc_ld = 1; pc_inc = 1; ir_ld = 1; adr_sel = 1; R_Adr = 6; tick();
        peek_pc("br_fwd", 16'h0015);
        check("br_ir_new", IR, 16'h0033);

        // Jump and wrap
        set_reg(3, 16'hFFFF);
        idle(); pc_ld = 1; pc_sel = 1; R_Adr = 3; tick();
        peek_pc("jmp_ffff", 16'hFFFF);
        idle(); pc_inc = 1; tick();
        peek_pc("wrap_0", 16'h0000);

        // STO addressing and no-bypass
        set_reg(4, 16'h0040);
        set_reg(5, 16'hBEEF);
        idle(); adr_sel = 1; R_Adr = 4; S_Adr = 5;
        #1;
        check("sto_addr", Address, 16'h0040);
        check("sto_data", D_out, 16'hBEEF);
        s_sel = 1; rw_en = 1; W_Adr = 5;
        tick();
        idle(); S_Adr = 5;
        #1;
        check("nobyp_next", D_out, 16'h1111);

        // Random control words
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 49) == 0);
            W_Adr   = 3'($urandom); R_Adr = 3'($urandom); S_Adr = 3'($urandom);
            adr_sel = 1'($urandom); s_sel = 1'($urandom); pc_ld = ($urandom_range(0, 3) == 0);
            pc_inc  = 1'($urandom); pc_sel = 1'($urandom); ir_ld = 1'($urandom);
            rw_en   = 1'($urandom); alu_op = 4'($urandom);
            tick();
            if (n % 8 == 0) peek_pc("rand_pc", m_pc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
